// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//
// Decode-and-issue stage that sits between ID and EX. Each cycle it decodes
// one 32-bit MIPS instruction and selects and extends the two ALU operands from
// the register-file read data. The result is captured into the ID/EX pipeline
// register, which supports stall (hold) and flush (bubble). Illegal
// instructions are issued as bubbles. They raise a one-cycle pulse and are
// counted in a saturating 8-bit counter.
//
// Ports
//   clk            pipeline clock, rising edge
//   rst            asynchronous, active-high reset
//   i_id_valid     instruction/operands on i_id_* are valid
//   i_id_instr     instruction word
//   i_id_rs_data   register file read of instr[25:21]
//   i_id_rt_data   register file read of instr[20:16]
//   i_stall        hold the ID/EX register
//   i_flush        load a bubble into the ID/EX register (wins over stall)
//   o_id_ready     combinational, = !i_stall
//   o_ex_valid     ID/EX holds a real operation
//   o_ex_op        ALU operation code
//   o_ex_src1/2    ALU operands
//   o_ex_dst       destination register
//   o_ex_reg_write result is written back (never for $0)
//   o_ex_ovf_trap  ALU overflow must raise an exception (add, sub, addi)
//   o_ex_mem_rd    lw
//   o_ex_mem_wr    sw
//   o_ex_branch    beq / bne
//   o_ex_illegal   one-cycle pulse: an undecodable instruction was accepted
//   o_illegal_cnt  saturating count of accepted illegal instructions
// -----------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_id_valid,
  input  logic [31:0]       i_id_instr,
  input  logic [DWIDTH-1:0] i_id_rs_data,
  input  logic [DWIDTH-1:0] i_id_rt_data,
  input  logic              i_stall,
  input  logic              i_flush,
  output logic              o_id_ready,
  output logic              o_ex_valid,
  output logic [3:0]        o_ex_op,
  output logic [DWIDTH-1:0] o_ex_src1,
  output logic [DWIDTH-1:0] o_ex_src2,
  output logic [4:0]        o_ex_dst,
  output logic              o_ex_reg_write,
  output logic              o_ex_ovf_trap,
  output logic              o_ex_mem_rd,
  output logic              o_ex_mem_wr,
  output logic              o_ex_branch,
  output logic              o_ex_illegal,
  output logic [7:0]        o_illegal_cnt
);

  // ALU operation encodings driven onto o_ex_op
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_SLL = 4'b1001,
    ALU_SRL = 4'b1010,
    ALU_NOR = 4'b1100,
    ALU_SRA = 4'b1101,
    ALU_LUI = 4'b1110
  } alu_op_e;

  // Primary opcodes
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ADDIU = 6'b001001;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_LUI   = 6'b001111;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;

  // R-type function codes
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  // Instruction fields and extended immediates
  logic [5:0]        w_opcode;
  logic [5:0]        w_funct;
  logic [4:0]        w_rd_field;
  logic [4:0]        w_rt_field;
  logic [DWIDTH-1:0] w_imm_sext;
  logic [DWIDTH-1:0] w_imm_zext;
  logic [DWIDTH-1:0] w_shamt_zext;

  assign w_opcode     = i_id_instr[31:26];
  assign w_funct      = i_id_instr[5:0];
  assign w_rd_field   = i_id_instr[15:11];
  assign w_rt_field   = i_id_instr[20:16];
  assign w_imm_sext   = {{(DWIDTH-16){i_id_instr[15]}}, i_id_instr[15:0]};
  assign w_imm_zext   = {{(DWIDTH-16){1'b0}}, i_id_instr[15:0]};
  assign w_shamt_zext = {{(DWIDTH-5){1'b0}}, i_id_instr[10:6]};

  // The rs specifier is consumed by the register file and never by this
  // stage; it is folded into a sink here so the unused bits are intentional.
  logic w_unused_rs_field;
  assign w_unused_rs_field = ^i_id_instr[25:21];

  // Decoded controls for the instruction currently on the ID inputs
  logic              w_legal;
  alu_op_e           w_op;
  logic [DWIDTH-1:0] w_src1;
  logic [DWIDTH-1:0] w_src2;
  logic [4:0]        w_dst;
  logic              w_writes;
  logic              w_ovf_trap;
  logic              w_mem_rd;
  logic              w_mem_wr;
  logic              w_branch;
  logic              w_reg_write;

  // Opcode/funct decode. Every field gets a default first so an unlisted
  // encoding simply drops out as illegal with all controls low. Shifts take
  // the shifted value from rt on src1 and the amount on src2, so the ALU
  // always shifts src1 by src2.
  always_comb begin
    w_legal    = 1'b1;
    w_op       = ALU_AND;
    w_src1     = i_id_rs_data;
    w_src2     = i_id_rt_data;
    w_dst      = '0;
    w_writes   = 1'b0;
    w_ovf_trap = 1'b0;
    w_mem_rd   = 1'b0;
    w_mem_wr   = 1'b0;
    w_branch   = 1'b0;
    case (w_opcode)
      OPC_RTYPE: begin
        w_dst    = w_rd_field;
        w_writes = 1'b1;
        case (w_funct)
          FN_ADD:  begin w_op = ALU_ADD; w_ovf_trap = 1'b1; end
          FN_ADDU: w_op = ALU_ADD;
          FN_SUB:  begin w_op = ALU_SUB; w_ovf_trap = 1'b1; end
          FN_SUBU: w_op = ALU_SUB;
          FN_AND:  w_op = ALU_AND;
          FN_OR:   w_op = ALU_OR;
          FN_NOR:  w_op = ALU_NOR;
          FN_SLT:  w_op = ALU_SLT;
          FN_SLL:  begin w_op = ALU_SLL; w_src1 = i_id_rt_data; w_src2 = w_shamt_zext; end
          FN_SRL:  begin w_op = ALU_SRL; w_src1 = i_id_rt_data; w_src2 = w_shamt_zext; end
          FN_SRA:  begin w_op = ALU_SRA; w_src1 = i_id_rt_data; w_src2 = w_shamt_zext; end
          FN_SLLV: begin w_op = ALU_SLL; w_src1 = i_id_rt_data; w_src2 = i_id_rs_data; end
          FN_SRLV: begin w_op = ALU_SRL; w_src1 = i_id_rt_data; w_src2 = i_id_rs_data; end
          FN_SRAV: begin w_op = ALU_SRA; w_src1 = i_id_rt_data; w_src2 = i_id_rs_data; end
          default: w_legal = 1'b0;
        endcase
      end
      OPC_ADDI: begin
        w_op = ALU_ADD; w_src2 = w_imm_sext; w_dst = w_rt_field;
        w_writes = 1'b1; w_ovf_trap = 1'b1;
      end
      OPC_ADDIU: begin
        w_op = ALU_ADD; w_src2 = w_imm_sext; w_dst = w_rt_field; w_writes = 1'b1;
      end
      OPC_SLTI: begin
        w_op = ALU_SLT; w_src2 = w_imm_sext; w_dst = w_rt_field; w_writes = 1'b1;
      end
      OPC_ANDI: begin
        w_op = ALU_AND; w_src2 = w_imm_zext; w_dst = w_rt_field; w_writes = 1'b1;
      end
      OPC_ORI: begin
        w_op = ALU_OR; w_src2 = w_imm_zext; w_dst = w_rt_field; w_writes = 1'b1;
      end
      OPC_LUI: begin
        w_op = ALU_LUI; w_src2 = w_imm_zext; w_dst = w_rt_field; w_writes = 1'b1;
      end
      OPC_LW: begin
        w_op = ALU_ADD; w_src2 = w_imm_sext; w_dst = w_rt_field;
        w_writes = 1'b1; w_mem_rd = 1'b1;
      end
      // Stores and branches have no destination, so dst stays 0
      OPC_SW: begin
        w_op = ALU_ADD; w_src2 = w_imm_sext; w_mem_wr = 1'b1;
      end
      OPC_BEQ, OPC_BNE: begin
        w_op = ALU_SUB; w_branch = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Writes to $0 are architecturally discarded, so they never request writeback
  assign w_reg_write = w_writes && (w_dst != 5'd0);

  assign o_id_ready = !i_stall;

  // ID/EX pipeline register
  logic              r_valid;
  logic [3:0]        r_op;
  logic [DWIDTH-1:0] r_src1;
  logic [DWIDTH-1:0] r_src2;
  logic [4:0]        r_dst;
  logic              r_reg_write;
  logic              r_ovf_trap;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic              r_branch;
  logic              r_illegal;
  logic [7:0]        r_illegal_cnt;

  // An instruction is consumed only on an edge with neither flush nor stall.
  logic w_accept;
  logic w_accept_illegal;
  assign w_accept         = i_id_valid && !i_stall && !i_flush;
  assign w_accept_illegal = w_accept && !w_legal;

  // Update priority: flush loads a bubble even while stalled. Stall freezes
  // the register and counter and only drops the illegal pulse. Otherwise a
  // legal accepted instruction is loaded and anything else becomes a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid       <= 1'b0;
      r_op          <= '0;
      r_src1        <= '0;
      r_src2        <= '0;
      r_dst         <= '0;
      r_reg_write   <= 1'b0;
      r_ovf_trap    <= 1'b0;
      r_mem_rd      <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_branch      <= 1'b0;
      r_illegal     <= 1'b0;
      r_illegal_cnt <= '0;
    end else if (i_stall && !i_flush) begin
      r_illegal <= 1'b0;
    end else if (w_accept && w_legal) begin
      r_valid     <= 1'b1;
      r_op        <= w_op;
      r_src1      <= w_src1;
      r_src2      <= w_src2;
      r_dst       <= w_dst;
      r_reg_write <= w_reg_write;
      r_ovf_trap  <= w_ovf_trap;
      r_mem_rd    <= w_mem_rd;
      r_mem_wr    <= w_mem_wr;
      r_branch    <= w_branch;
      r_illegal   <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_op        <= '0;
      r_src1      <= '0;
      r_src2      <= '0;
      r_dst       <= '0;
      r_reg_write <= 1'b0;
      r_ovf_trap  <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_branch    <= 1'b0;
      r_illegal   <= w_accept_illegal;
      if (w_accept_illegal && (r_illegal_cnt != 8'hFF)) begin
        r_illegal_cnt <= r_illegal_cnt + 8'd1;
      end
    end
  end

  assign o_ex_valid     = r_valid;
  assign o_ex_op        = r_op;
  assign o_ex_src1      = r_src1;
  assign o_ex_src2      = r_src2;
  assign o_ex_dst       = r_dst;
  assign o_ex_reg_write = r_reg_write;
  assign o_ex_ovf_trap  = r_ovf_trap;
  assign o_ex_mem_rd    = r_mem_rd;
  assign o_ex_mem_wr    = r_mem_wr;
  assign o_ex_branch    = r_branch;
  assign o_ex_illegal   = r_illegal;
  assign o_illegal_cnt  = r_illegal_cnt;

endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Self-checking bench for alu_issue_stage. A reference model written in terms
// of MIPS mnemonics predicts the ID/EX contents after every edge. The bench
// compares it against the DUT outputs, which are sampled 1 ns after each
// rising edge.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

  logic        clk;
  logic        rst;
  logic        idValid;
  logic [31:0] idInstr;
  logic [31:0] idRsData;
  logic [31:0] idRtData;
  logic        stall;
  logic        flush;
  logic        idReady;
  logic        exValid;
  logic [3:0]  exOp;
  logic [31:0] exSrc1;
  logic [31:0] exSrc2;
  logic [4:0]  exDst;
  logic        exRegWrite;
  logic        exOvfTrap;
  logic        exMemRd;
  logic        exMemWr;
  logic        exBranch;
  logic        exIllegal;
  logic [7:0]  illegalCnt;

  alu_issue_stage #(.DWIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_id_valid     (idValid),
    .i_id_instr     (idInstr),
    .i_id_rs_data   (idRsData),
    .i_id_rt_data   (idRtData),
    .i_stall        (stall),
    .i_flush        (flush),
    .o_id_ready     (idReady),
    .o_ex_valid     (exValid),
    .o_ex_op        (exOp),
    .o_ex_src1      (exSrc1),
    .o_ex_src2      (exSrc2),
    .o_ex_dst       (exDst),
    .o_ex_reg_write (exRegWrite),
    .o_ex_ovf_trap  (exOvfTrap),
    .o_ex_mem_rd    (exMemRd),
    .o_ex_mem_wr    (exMemWr),
    .o_ex_branch    (exBranch),
    .o_ex_illegal   (exIllegal),
    .o_illegal_cnt  (illegalCnt)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU op names as the ALU documents them
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010,
                         OP_SUB = 4'b0110, OP_NOR = 4'b1100, OP_SLT = 4'b0111,
                         OP_SLL = 4'b1001, OP_SRL = 4'b1010, OP_SRA = 4'b1101,
                         OP_LUI = 4'b1110;

  localparam logic [5:0] RFUNCTS [14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27,
                                          6'h2A, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
  localparam logic [5:0] IOPS [10] = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F,
                                       6'h23, 6'h2B, 6'h04, 6'h05};

  // Everything visible on the EX side, packed so one compare covers it all
  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  dst;
    logic        rw;
    logic        ovf;
    logic        rd;
    logic        wr;
    logic        br;
    logic        ill;
    logic [7:0]  cnt;
  } exp_t;

  exp_t m;
  int   mCnt;
  bit   mCare;
  int   checks;
  int   passes;

  // One issued operation; writeback to $0 never counts as a write
  function automatic exp_t mk(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                              logic [4:0] d, bit writes, bit trap, bit ld, bit st, bit br);
    exp_t e;
    e = '0;
    e.valid = 1'b1; e.op = op; e.src1 = a; e.src2 = b; e.dst = d;
    e.rw = writes && (d != 5'd0); e.ovf = trap; e.rd = ld; e.wr = st; e.br = br;
    return e;
  endfunction

  // Mnemonic-level meaning of an instruction
  task automatic modelDecode(input logic [31:0] ins, input logic [31:0] rsV, input logic [31:0] rtV,
                             output exp_t e, output bit legal, output bit care);
    logic [4:0]  rdF, rtF;
    logic [31:0] se, ze, sh;
    rdF = ins[15:11];
    rtF = ins[20:16];
    se  = {{16{ins[15]}}, ins[15:0]};
    ze  = {16'h0000, ins[15:0]};
    sh  = {27'd0, ins[10:6]};
    legal = 1'b1;
    care  = 1'b1;
    e     = '0;
    if (ins[31:26] == 6'h00) begin
      case (ins[5:0])
        6'h20: e = mk(OP_ADD, rsV, rtV, rdF, 1, 1, 0, 0, 0);   // add
        6'h21: e = mk(OP_ADD, rsV, rtV, rdF, 1, 0, 0, 0, 0);   // addu
        6'h22: e = mk(OP_SUB, rsV, rtV, rdF, 1, 1, 0, 0, 0);   // sub
        6'h23: e = mk(OP_SUB, rsV, rtV, rdF, 1, 0, 0, 0, 0);   // subu
        6'h24: e = mk(OP_AND, rsV, rtV, rdF, 1, 0, 0, 0, 0);   // and
        6'h25: e = mk(OP_OR,  rsV, rtV, rdF, 1, 0, 0, 0, 0);   // or
        6'h27: e = mk(OP_NOR, rsV, rtV, rdF, 1, 0, 0, 0, 0);   // nor
        6'h2A: e = mk(OP_SLT, rsV, rtV, rdF, 1, 0, 0, 0, 0);   // slt
        6'h00: e = mk(OP_SLL, rtV, sh,  rdF, 1, 0, 0, 0, 0);   // sll
        6'h02: e = mk(OP_SRL, rtV, sh,  rdF, 1, 0, 0, 0, 0);   // srl
        6'h03: e = mk(OP_SRA, rtV, sh,  rdF, 1, 0, 0, 0, 0);   // sra
        6'h04: e = mk(OP_SLL, rtV, rsV, rdF, 1, 0, 0, 0, 0);   // sllv
        6'h06: e = mk(OP_SRL, rtV, rsV, rdF, 1, 0, 0, 0, 0);   // srlv
        6'h07: e = mk(OP_SRA, rtV, rsV, rdF, 1, 0, 0, 0, 0);   // srav
        default: legal = 1'b0;
      endcase
    end else begin
      case (ins[31:26])
        6'h08: e = mk(OP_ADD, rsV, se, rtF, 1, 1, 0, 0, 0);    // addi
        6'h09: e = mk(OP_ADD, rsV, se, rtF, 1, 0, 0, 0, 0);    // addiu
        6'h0A: e = mk(OP_SLT, rsV, se, rtF, 1, 0, 0, 0, 0);    // slti
        6'h0C: e = mk(OP_AND, rsV, ze, rtF, 1, 0, 0, 0, 0);    // andi
        6'h0D: e = mk(OP_OR,  rsV, ze, rtF, 1, 0, 0, 0, 0);    // ori
        6'h0F: e = mk(OP_LUI, rsV, ze, rtF, 1, 0, 0, 0, 0);    // lui
        6'h23: e = mk(OP_ADD, rsV, se, rtF, 1, 0, 1, 0, 0);    // lw
        6'h2B: begin e = mk(OP_ADD, rsV, se, 5'd0, 0, 0, 0, 1, 0); care = 1'b0; end  // sw
        6'h04, 6'h05: begin e = mk(OP_SUB, rsV, rtV, 5'd0, 0, 0, 0, 0, 1); care = 1'b0; end  // beq/bne
        default: legal = 1'b0;
      endcase
    end
    if (!legal) e = '0;
  endtask

  // Predicts the effect of the next rising edge from the current inputs
  task automatic modelEdge();
    exp_t d;
    bit   lg, cr;
    if (flush) begin
      m = '0; mCare = 1'b1;
    end else if (stall) begin
      m.ill = 1'b0;
    end else if (!idValid) begin
      m = '0; mCare = 1'b1;
    end else begin
      modelDecode(idInstr, idRsData, idRtData, d, lg, cr);
      if (lg) begin
        m = d; mCare = cr;
      end else begin
        m = '0; m.ill = 1'b1; mCare = 1'b1;
        if (mCnt < 255) mCnt++;
      end
    end
    m.cnt = mCnt[7:0];
  endtask

  // Snapshot of the DUT; dst is masked where the instruction has no destination
  function automatic exp_t observe();
    exp_t o;
    o = {exValid, exOp, exSrc1, exSrc2, (mCare ? exDst : m.dst), exRegWrite,
         exOvfTrap, exMemRd, exMemWr, exBranch, exIllegal, illegalCnt};
    return o;
  endfunction

  function automatic logic [31:0] randInstr();
    logic [31:0] r;
    int k;
    r = $urandom();
    k = $urandom_range(0, 9);
    if (k < 4) begin
      r[31:26] = 6'h00;
      r[5:0]   = RFUNCTS[$urandom_range(0, 13)];
    end else if (k < 9) begin
      r[31:26] = IOPS[$urandom_range(0, 9)];
    end
    return r;
  endfunction

  task automatic setInputs(bit v, logic [31:0] ins, logic [31:0] rsV, logic [31:0] rtV, bit st, bit fl);
    idValid = v; idInstr = ins; idRsData = rsV; idRtData = rtV; stall = st; flush = fl;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    setInputs(1, 32'h00221820, 32'd5, 32'd7, 0, 0);
    m = '0; mCnt = 0; mCare = 1'b1;
    #3;
    checks++;
    if (observe() !== m) $display("[TB] FAIL reset_state got %h want %h", observe(), m);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    setInputs(0, 32'h0, 32'h0, 32'h0, 0, 0);
    modelEdge();
    @(posedge clk); #1;
    checks++;
    if (observe() !== m) $display("[TB] FAIL reset_idle_edge got %h want %h", observe(), m);
    else passes++;
  endtask

  task automatic test_directed();
    logic [31:0] ins [10] = '{32'h00221820, 32'h2024FFFF, 32'h3424FFFF, 32'h3C051234, 32'h00031103,
                             32'h10220010, 32'hAC220008, 32'h00220021, 32'h00000000, 32'h8C23FFF0};
    logic [31:0] rsv [10] = '{32'd5, 32'd10, 32'd10, 32'd0, 32'd9, 32'd3, 32'h100, 32'd1, 32'd0, 32'h2000};
    logic [31:0] rtv [10] = '{32'd7, 32'd0, 32'd0, 32'd0, 32'h80000000, 32'd3, 32'd44, 32'd2, 32'd0, 32'd0};
    for (int i = 0; i < 10; i++) begin
      setInputs(1, ins[i], rsv[i], rtv[i], 0, 0);
      modelEdge();
      @(posedge clk); #1;
      checks++;
      if (observe() !== m) $display("[TB] FAIL directed_%0d got %h want %h", i, observe(), m);
      else passes++;
      if (i == 0) begin
        checks++;
        if ({exOp, exSrc1, exSrc2, exDst, exRegWrite, exOvfTrap} !== {4'b0010, 32'd5, 32'd7, 5'd3, 1'b1, 1'b1})
          $display("[TB] FAIL add_fields got op %b src1 %0d src2 %0d dst %0d rw %b trap %b want 0010 5 7 3 1 1",
                   exOp, exSrc1, exSrc2, exDst, exRegWrite, exOvfTrap);
        else passes++;
      end
      if (i == 4) begin
        checks++;
        if ({exOp, exSrc1, exSrc2, exDst} !== {4'b1101, 32'h80000000, 32'd4, 5'd2})
          $display("[TB] FAIL sra_fields got op %b src1 %h src2 %0d dst %0d want 1101 80000000 4 2",
                   exOp, exSrc1, exSrc2, exDst);
        else passes++;
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      setInputs(1, randInstr(), $urandom(), $urandom(), 0, 0);
      modelEdge();
      @(posedge clk); #1;
      checks++;
      if (observe() !== m) $display("[TB] FAIL back_to_back_%0d instr %h got %h want %h", i, idInstr, observe(), m);
      else passes++;
    end
  endtask

  task automatic test_stall_flush();
    int cntBefore;
    setInputs(1, 32'h00221820, 32'd11, 32'd22, 0, 0);
    modelEdge();
    @(posedge clk); #1;
    checks++;
    if (observe() !== m) $display("[TB] FAIL stall_load got %h want %h", observe(), m);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      setInputs(1, randInstr(), $urandom(), $urandom(), 1, 0);
      modelEdge();
      @(posedge clk); #1;
      checks++;
      if (observe() !== m) $display("[TB] FAIL stall_hold_%0d got %h want %h", i, observe(), m);
      else passes++;
    end
    setInputs(1, 32'h00221820, 32'd1, 32'd2, 1, 1);
    modelEdge();
    @(posedge clk); #1;
    checks++;
    if (observe() !== m) $display("[TB] FAIL flush_over_stall got %h want %h", observe(), m);
    else passes++;
    cntBefore = mCnt;
    setInputs(1, 32'hFC000000, 32'd0, 32'd0, 1, 0);
    modelEdge();
    @(posedge clk); #1;
    checks++;
    if (observe() !== m || illegalCnt !== cntBefore[7:0])
      $display("[TB] FAIL illegal_under_stall got %h cnt %0d want %h cnt %0d", observe(), illegalCnt, m, cntBefore);
    else passes++;
    setInputs(1, 32'hFC000000, 32'd0, 32'd0, 0, 1);
    modelEdge();
    @(posedge clk); #1;
    checks++;
    if (observe() !== m || exIllegal !== 1'b0)
      $display("[TB] FAIL illegal_under_flush got %h want %h", observe(), m);
    else passes++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      setInputs($urandom_range(0, 9) != 0, randInstr(), $urandom(), $urandom(),
                $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      #1;
      checks++;
      if (idReady !== !stall) $display("[TB] FAIL id_ready_%0d got %b want %b", i, idReady, !stall);
      else passes++;
      modelEdge();
      @(posedge clk); #1;
      checks++;
      if (observe() !== m) $display("[TB] FAIL random_%0d instr %h got %h want %h", i, idInstr, observe(), m);
      else passes++;
    end
  endtask

  task automatic test_illegal_flood();
    for (int i = 0; i < 260; i++) begin
      setInputs(1, 32'hFC000000, $urandom(), $urandom(), 0, 0);
      modelEdge();
      @(posedge clk); #1;
      checks++;
      if (observe() !== m) $display("[TB] FAIL illegal_flood_%0d got %h want %h", i, observe(), m);
      else passes++;
    end
    checks++;
    if (illegalCnt !== 8'd255) $display("[TB] FAIL illegal_saturate got %0d want 255", illegalCnt);
    else passes++;
  endtask

  task automatic test_mid_reset();
    setInputs(1, 32'h3C051234, 32'd0, 32'd0, 0, 0);
    modelEdge();
    @(posedge clk); #2;
    rst = 1'b1;
    setInputs(1, 32'h2024FFFF, 32'd10, 32'd0, 0, 0);
    m = '0; mCnt = 0; mCare = 1'b1;
    #1;
    checks++;
    if (observe() !== m) $display("[TB] FAIL mid_reset got %h want %h", observe(), m);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    modelEdge();
    @(posedge clk); #1;
    checks++;
    if (observe() !== m) $display("[TB] FAIL after_reset_edge got %h want %h", observe(), m);
    else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall_flush();
    test_random();
    test_illegal_flood();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-and-issue stage that drives the ALU from the ID side of the pipelined CPU. Each cycle it accepts one 32-bit MIPS instruction plus its register-file read data. It decodes the 4-bit ALU operation code and selects/extends both operands. The result is captured into an ID/EX pipeline register with stall/flush control. It also tracks illegal instructions and flags which operations must trap on ALU overflow.

## Interface
- DWIDTH, 32, datapath width; operand outputs are DWIDTH bits (decode logic fixed for 32-bit MIPS encoding)
- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous, active-high reset
- id_valid  input  1  instruction/operands on id_* are valid
- id_instr  input  32  instruction word
- id_rs_data  input  DWIDTH  register file read of instr[25:21]
- id_rt_data  input  DWIDTH  register file read of instr[20:16]
- stall  input  1  hold ID/EX register
- flush  input  1  replace ID/EX contents with bubble
- id_ready  output  1  combinational, = !stall
- ex_valid  output  1  ID/EX holds a real operation
- ex_op  output  4  ALU op: AND 0000, OR 0001, ADD 0010, SUB 0110, NOR 1100, SLT 0111, SLL 1001, SRL 1010, SRA 1101, LUI 1110
- ex_src1  output  DWIDTH  ALU rs1 input
- ex_src2  output  DWIDTH  ALU rs2 input
- ex_dst  output  5  destination register
- ex_reg_write  output  1  result written back
- ex_ovf_trap  output  1  ALU overflow must raise exception (add, sub, addi only)
- ex_mem_rd / ex_mem_wr / ex_branch  output  1 each  lw / sw / beq-or-bne
- ex_illegal  output  1  one-cycle pulse: an undecodable instruction was accepted
- illegal_cnt  output  8  saturating count of illegal instructions

## Operation
- R-type (op 000000), by funct, src1/src2:
  - add 100000 → ADD, rs/rt, trap
  - addu 100001 → ADD, rs/rt
  - sub 100010 → SUB, trap
  - subu 100011 → SUB
  - and 100100 → AND
  - or 100101 → OR
  - nor 100111 → NOR
  - slt 101010 → SLT
- R-type shifts:
  - sll 000000, srl 000010, sra 000011: src1 = rt, src2 = zero-extended shamt instr[10:6]
  - sllv 000100, srlv 000110, srav 000111: src1 = rt, src2 = rs
- All R-type: dst = instr[15:11].
- I-type, dst = instr[20:16], src1 = rs:
  - addi 001000 → ADD, sign-extended imm, trap
  - addiu 001001 → ADD, sign-extended imm
  - slti 001010 → SLT, sign-extended imm
  - andi 001100 → AND, zero-extended imm
  - ori 001101 → OR, zero-extended imm
  - lui 001111 → LUI, src2 = zero-extended imm
  - lw 100011 → ADD, sign-extended imm, mem_rd
- No-writeback ops:
  - sw 101011 → ADD, sign-extended imm, mem_wr, reg_write 0
  - beq 000100, bne 000101 → SUB, src2 = rt, branch, reg_write 0
- ex_reg_write forced 0 when dst = 0. sll $0,$0,0 (nop) is a valid instruction with reg_write 0.
- Illegal instruction is any other opcode or funct.
  - Issued as a bubble (ex_valid 0, all controls 0).
  - ex_illegal pulses for that cycle.
  - illegal_cnt increments, saturating at 255.
- A bubble (not id_valid, flush, or illegal) sets ex_valid, ex_reg_write, ex_mem_rd, ex_mem_wr, ex_branch, ex_ovf_trap, ex_illegal to 0. ex_op/src/dst are don't-care but driven to 0.

## Timing
- Reset (async, immediate): every ex_* output 0, illegal_cnt 0.
- Latency 1 cycle: id_* sampled at rising edge, visible on ex_* after it.
- Update priority per edge:
  - flush: load bubble, regardless of stall.
  - else stall: hold all ex_* and illegal_cnt unchanged; ex_illegal held at 0; no decode side effects.
  - else: load decode of id_* (bubble if !id_valid).
- Illegal instruction under stall or flush: not counted, no pulse.
- id_ready = !stall; an instruction is accepted only on an edge with id_valid && !stall && !flush.
- Reset asserted mid-stream discards the held instruction; the first edge after deassertion behaves as a normal edge.

## Test plan
- Reset → ex_valid 0, illegal_cnt 0. Then add $3,$1,$2 (0x00221820), rs 5, rt 7 → next cycle: ex_op 0010, src1 5, src2 7, dst 3, reg_write 1, ovf_trap 1.
- addi $4,$1,-1 (0x2024FFFF), rs 10 → src2 0xFFFFFFFF, op 0010, dst 4. ori $4,$1,0xFFFF → src2 0x0000FFFF, op 0001. lui $5,0x1234 → op 1110, src2 0x00001234.
- sra $2,$3,4 (0x00031103), rt 0x80000000 → op 1101, src1 0x80000000, src2 4, dst 2.
- beq and sw → reg_write 0, branch/mem_wr 1, op 0110/0010. Write to $0 → reg_write 0.
- Stall held 3 cycles with changing id_* → ex_* unchanged. Flush and stall in the same cycle → bubble loaded.
- 260 illegal opcodes (0xFC000000) → ex_valid 0, ex_illegal pulses each cycle, illegal_cnt stops at 255. Illegal instruction during stall → no count.
